// File: rtl/bpu_ftq.sv
// Fetch Target Queue between the uBTB stage and the IFU; entries are held until commit,
// which produces the uBTB training write. Optional same-cycle bypass: `define FTQ_BYPASS_EN.
module bpu_ftq #(
  parameter int MXLEN     = 32,
  parameter int FTQ_DEPTH = 8,
  parameter int PTR_W     = $clog2(FTQ_DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_enq_valid,
  input  logic [MXLEN-1:0] i_enq_pc,
  input  logic             i_enq_taken,
  input  logic [MXLEN-1:0] i_enq_target,
  output logic             o_enq_ready,
  output logic             o_deq_valid,
  input  logic             i_deq_ready,
  output logic [MXLEN-1:0] o_deq_pc,
  output logic             o_deq_taken,
  output logic [MXLEN-1:0] o_deq_target,
  output logic [PTR_W-1:0] o_deq_ptr,
  input  logic             i_commit_valid,
  input  logic             i_commit_taken,
  input  logic [MXLEN-1:0] i_commit_target,
  input  logic             i_redirect_valid,
  input  logic [PTR_W-1:0] i_redirect_ptr,
  output logic             o_ubtb_update,
  output logic [MXLEN-1:0] o_pc_jumpsrc,
  output logic [MXLEN-1:0] o_pc_jumpdst,
  output logic [PTR_W-1:0] o_count
);
  localparam int IDX_W = PTR_W - 1;

  typedef struct packed {
    logic [MXLEN-1:0] pc;
    logic             taken;
    logic [MXLEN-1:0] target;
  } ent_t;

  ent_t             mem_q [FTQ_DEPTH];
  logic [PTR_W-1:0] enq_ptr_q, enq_ptr_d;
  logic [PTR_W-1:0] fetch_ptr_q, fetch_ptr_d;
  logic [PTR_W-1:0] cmt_ptr_q, cmt_ptr_d;
  logic [PTR_W-1:0] count, redir_nxt, rd_off, fe_off;
  logic             full, fetch_empty, enq_fire, deq_fire, train;
  ent_t             enq_ent, fetch_ent, cmt_ent, deq_ent;
  logic             upd_q, upd_d;
  logic [MXLEN-1:0] src_q, src_d, dst_q, dst_d;

  assign enq_ent     = '{pc: i_enq_pc, taken: i_enq_taken, target: i_enq_target};
  assign count       = enq_ptr_q - cmt_ptr_q;
  assign full        = (count == PTR_W'(FTQ_DEPTH));
  assign fetch_empty = (fetch_ptr_q == enq_ptr_q);
  assign o_enq_ready = !full && !i_redirect_valid;
  assign enq_fire    = i_enq_valid && o_enq_ready;
  assign fetch_ent   = mem_q[fetch_ptr_q[IDX_W-1:0]];
  assign cmt_ent     = mem_q[cmt_ptr_q[IDX_W-1:0]];

`ifdef FTQ_BYPASS_EN
  // An enqueue into an empty fetch window is forwarded straight to the IFU.
  assign o_deq_valid = !fetch_empty || enq_fire;
  assign deq_ent     = fetch_empty ? enq_ent : fetch_ent;
`else
  assign o_deq_valid = !fetch_empty;
  assign deq_ent     = fetch_ent;
`endif

  assign deq_fire     = o_deq_valid && i_deq_ready && !i_redirect_valid;
  assign o_deq_pc     = o_deq_valid ? deq_ent.pc     : '0;
  assign o_deq_taken  = o_deq_valid ? deq_ent.taken  : 1'b0;
  assign o_deq_target = o_deq_valid ? deq_ent.target : '0;
  assign o_deq_ptr    = fetch_ptr_q;
  assign o_count      = count;

  assign redir_nxt = i_redirect_ptr + {{(PTR_W-1){1'b0}}, 1'b1};

  always_comb begin
    enq_ptr_d   = enq_ptr_q   + {{(PTR_W-1){1'b0}}, enq_fire};
    fetch_ptr_d = fetch_ptr_q + {{(PTR_W-1){1'b0}}, deq_fire};
    cmt_ptr_d   = cmt_ptr_q   + {{(PTR_W-1){1'b0}}, i_commit_valid};
    if (i_redirect_valid) begin
      enq_ptr_d   = redir_nxt;
      fetch_ptr_d = redir_nxt;
    end
  end

  // Train only when the resolved jump disagrees with what the uBTB predicted.
  assign train = i_commit_valid && i_commit_taken &&
                 (!cmt_ent.taken || (cmt_ent.target != i_commit_target));

  always_comb begin
    upd_d = train;
    src_d = src_q;
    dst_d = dst_q;
    if (train) begin
      src_d = cmt_ent.pc;
      dst_d = i_commit_target;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      enq_ptr_q   <= '0;
      fetch_ptr_q <= '0;
      cmt_ptr_q   <= '0;
      upd_q       <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
    end else begin
      enq_ptr_q   <= enq_ptr_d;
      fetch_ptr_q <= fetch_ptr_d;
      cmt_ptr_q   <= cmt_ptr_d;
      upd_q       <= upd_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (enq_fire) mem_q[enq_ptr_q[IDX_W-1:0]] <= enq_ent;
  end

  assign o_ubtb_update = upd_q;
  assign o_pc_jumpsrc  = src_q;
  assign o_pc_jumpdst  = dst_q;

  // Redirect target must be a fetched, not-yet-committed entry (post-commit window).
  assign rd_off = i_redirect_ptr - cmt_ptr_d;
  assign fe_off = fetch_ptr_q - cmt_ptr_d;

  a_commit_nonempty: assert property (@(posedge i_clk) disable iff (!i_rstn)
    !(i_commit_valid && (count == '0)));
  a_redirect_range: assert property (@(posedge i_clk) disable iff (!i_rstn)
    i_redirect_valid |-> (rd_off < fe_off));

endmodule

// File: tb/tb_bpu_ftq.sv
// Randomised scoreboard bench for bpu_ftq: a queue-based reference model predicts
// dequeue order, pointers, occupancy and uBTB training writes.
module tb_bpu_ftq;
  localparam int MXLEN = 32;
  localparam int DEPTH = 8;
  localparam int PW    = 4;

  logic             i_clk = 1'b0;
  logic             i_rstn;
  logic             i_enq_valid, i_enq_taken, i_deq_ready;
  logic [MXLEN-1:0] i_enq_pc, i_enq_target;
  logic             o_enq_ready, o_deq_valid, o_deq_taken;
  logic [MXLEN-1:0] o_deq_pc, o_deq_target;
  logic [PW-1:0]    o_deq_ptr, o_count, i_redirect_ptr;
  logic             i_commit_valid, i_commit_taken, i_redirect_valid;
  logic [MXLEN-1:0] i_commit_target, o_pc_jumpsrc, o_pc_jumpdst;
  logic             o_ubtb_update;

  bpu_ftq #(.MXLEN(MXLEN), .FTQ_DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_enq_valid(i_enq_valid), .i_enq_pc(i_enq_pc), .i_enq_taken(i_enq_taken),
    .i_enq_target(i_enq_target), .o_enq_ready(o_enq_ready),
    .o_deq_valid(o_deq_valid), .i_deq_ready(i_deq_ready), .o_deq_pc(o_deq_pc),
    .o_deq_taken(o_deq_taken), .o_deq_target(o_deq_target), .o_deq_ptr(o_deq_ptr),
    .i_commit_valid(i_commit_valid), .i_commit_taken(i_commit_taken),
    .i_commit_target(i_commit_target), .i_redirect_valid(i_redirect_valid),
    .i_redirect_ptr(i_redirect_ptr), .o_ubtb_update(o_ubtb_update),
    .o_pc_jumpsrc(o_pc_jumpsrc), .o_pc_jumpdst(o_pc_jumpdst), .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] pc;
    logic        tk;
    logic [31:0] tgt;
    int          ptr;
  } ent_t;

  typedef struct {
    logic        upd;
    logic [31:0] src;
    logic [31:0] dst;
  } trn_t;

  ent_t        res[$];      // resident entries, oldest (commit head) first
  ent_t        exp_deq[$];  // entries the IFU has yet to receive, in order
  trn_t        trn_q[$];
  int          m_enq, m_cmt, nf;
  logic [31:0] last_src, last_dst;
  int          n_cmp = 0, n_err = 0;
  logic        pend = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    res.delete(); exp_deq.delete(); trn_q.delete();
    m_enq = 0; m_cmt = 0; nf = 0; last_src = '0; last_dst = '0;
  endtask

  task automatic idle_inputs();
    i_enq_valid = 0; i_enq_pc = '0; i_enq_taken = 0; i_enq_target = '0;
    i_deq_ready = 0; i_commit_valid = 0; i_commit_taken = 0; i_commit_target = '0;
    i_redirect_valid = 0; i_redirect_ptr = '0;
  endtask

  task automatic do_reset();
    @(posedge i_clk); #1;
    i_rstn = 0;
    idle_inputs();
    #1;
    chk("rst_count", 64'(o_count), 0);
    chk("rst_deq_valid", 64'(o_deq_valid), 0);
    chk("rst_ubtb_update", 64'(o_ubtb_update), 0);
    chk("rst_jumpsrc", 64'(o_pc_jumpsrc), 0);
    chk("rst_deq_pc", 64'(o_deq_pc), 0);
    model_clear();
    @(posedge i_clk); @(posedge i_clk); #1;
    i_rstn = 1;
  endtask

  // One clock of stimulus; roff is the redirect offset from the post-commit head.
  task automatic cyc(input logic ev, input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic dr, input logic cv, input logic ct, input logic [31:0] ctgt,
                     input logic rv, input int roff);
    int   cnt, avail;
    logic rdy, ef, dv, df, upd;
    ent_t e;
    @(posedge i_clk); #1;
    i_enq_valid = ev; i_enq_pc = pc; i_enq_taken = tk; i_enq_target = tgt;
    i_deq_ready = dr; i_commit_valid = cv; i_commit_taken = ct; i_commit_target = ctgt;
    i_redirect_valid = rv; i_redirect_ptr = PW'(m_cmt + int'(cv) + roff);
    cnt   = res.size();
    avail = cnt - nf;
    rdy   = (cnt < DEPTH) && !rv;
    ef    = ev && rdy;
`ifdef FTQ_BYPASS_EN
    dv = (avail > 0) || ef;
`else
    dv = (avail > 0);
`endif
    df = dv && dr && !rv;
    #1;
    chk("enq_ready", 64'(o_enq_ready), 64'(rdy));
    chk("deq_valid", 64'(o_deq_valid), 64'(dv));
    chk("count", 64'(o_count), 64'(cnt));
    chk("deq_ptr", 64'(o_deq_ptr), 64'((m_cmt + nf) % 16));
    if (ef) begin
      e.pc = pc; e.tk = tk; e.tgt = tgt; e.ptr = m_enq % 16;
      res.push_back(e); exp_deq.push_back(e); m_enq++;
    end
    if (df) nf++;
    if (cv) begin
      e = res.pop_front(); nf--; m_cmt++;
      upd = ct && (!e.tk || e.tgt != ctgt);
      if (upd) begin last_src = e.pc; last_dst = ctgt; end
      trn_q.push_back('{upd: upd, src: last_src, dst: last_dst});
    end
    if (rv) begin
      while (res.size() > roff + 1) void'(res.pop_back());
      nf = res.size();
      exp_deq.delete();
      m_enq = m_cmt + roff + 1;
    end
  endtask

  task automatic idle(input logic dr, input logic cv);
    cyc(0, 0, 0, 0, dr, cv, 0, 0, 0, 0);
  endtask

  task automatic enq(input logic [31:0] pc, input logic dr, input logic cv);
    cyc(1, pc, 0, pc + 32'h100, dr, cv, 0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && res.size() > 0; i++) idle(1, nf > 0);
    idle(0, 0);
  endtask

  // Monitor: pops expectations whenever the DUT hands over an entry or a training result.
  always @(negedge i_clk) begin
    ent_t e;
    trn_t t;
    if (!i_rstn) begin
      pend = 1'b0;
    end else begin
      if (o_deq_valid && i_deq_ready && !i_redirect_valid) begin
        if (exp_deq.size() == 0) chk("deq_unexpected", 64'(o_deq_valid), 0);
        else begin
          e = exp_deq.pop_front();
          chk("deq_pc", 64'(o_deq_pc), 64'(e.pc));
          chk("deq_taken", 64'(o_deq_taken), 64'(e.tk));
          chk("deq_target", 64'(o_deq_target), 64'(e.tgt));
          chk("deq_entry_ptr", 64'(o_deq_ptr), 64'(e.ptr));
        end
      end
      if (pend) begin
        if (trn_q.size() == 0) chk("trn_missing", 1, 0);
        else begin
          t = trn_q.pop_front();
          chk("ubtb_update", 64'(o_ubtb_update), 64'(t.upd));
          chk("pc_jumpsrc", 64'(o_pc_jumpsrc), 64'(t.src));
          chk("pc_jumpdst", 64'(o_pc_jumpdst), 64'(t.dst));
        end
      end else begin
        chk("ubtb_idle", 64'(o_ubtb_update), 0);
      end
      pend = i_commit_valid;
    end
  end

  initial begin
    logic        ev, dr, cv, ct, tk, rv;
    logic [31:0] ctgt, tgt;
    int          roff;
    i_rstn = 0;
    idle_inputs();
    model_clear();
    do_reset();

    // single entry round trip
    enq(32'h1000, 1, 0);
    idle(1, 0);
    idle(1, 0);
    idle(1, 1);

    // fill to full, refused 9th, one commit frees a slot
    for (int i = 0; i < DEPTH; i++) enq(32'h1100 + 4 * i, 1, 0);
    enq(32'h1F00, 1, 0);
    idle(1, 1);
    idle(1, 0);
    drain();

    // continuous flow across pointer wrap
    do_reset();
    for (int i = 0; i < 20; i++) enq(32'h4000 + 4 * i, 1, nf > 0);
    drain();

    // training: mispredicted then correctly predicted commit
    cyc(1, 32'h2000, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    idle(1, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 32'h3000, 0, 0);
    idle(0, 0);
    cyc(1, 32'h2100, 1, 32'h5000, 0, 0, 0, 0, 0, 0);
    idle(1, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 32'h5000, 0, 0);
    idle(0, 0);
    idle(0, 0);

    // redirect squashes younger entries and drops the same-cycle enqueue
    do_reset();
    for (int i = 0; i < 5; i++) enq(32'h6000 + 4 * i, 0, 0);
    for (int i = 0; i < 4; i++) idle(1, 0);
    cyc(1, 32'h6F00, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(0, 0);
    drain();

    // reset with entries in flight
    for (int i = 0; i < 3; i++) enq(32'h7000 + 4 * i, 0, 0);
    do_reset();
    enq(32'h7100, 1, 0);
    idle(1, 0);
    drain();

    // randomised traffic
    for (int i = 0; i < 600; i++) begin
      ev   = ($urandom % 10) < 7;
      dr   = ($urandom % 10) < 7;
      cv   = (nf > 0) && ($urandom % 2 == 1);
      ct   = $urandom % 2;
      tk   = $urandom % 2;
      tgt  = 32'h8000 + 4 * ($urandom % 4);
      ctgt = (cv && ($urandom % 2 == 1)) ? res[0].tgt : 32'h8000 + 4 * ($urandom % 4);
      rv   = ((nf - int'(cv)) > 0) && ($urandom % 20 == 0);
      roff = rv ? int'($urandom_range(0, nf - int'(cv) - 1)) : 0;
      cyc(ev, 32'h9000 + 4 * i, tk, tgt, dr, cv, ct, ctgt, rv, roff);
    end
    drain();
    idle(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
